// File: rtl/knn_topk_select_if.sv
// Handshake and result bundle for the k-nearest-neighbour top-5 selector.
// The master side is the query driver / result consumer; the slave side is the selector.
interface knn_topk_select_if #(
    parameter int DIST_W = 16
);
    logic              start;
    logic              K_mode;
    logic              in_valid;
    logic              in_ready;
    logic [DIST_W-1:0] in_dist;
    logic [1:0]        in_label;
    logic              in_last;
    logic [1:0]        class1;
    logic [1:0]        class2;
    logic [1:0]        class3;
    logic [1:0]        class4;
    logic [1:0]        class5;
    logic              K_mode_out;
    logic [2:0]        out_count;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output start, K_mode, in_valid, in_dist, in_label, in_last, out_ready,
        input  in_ready, class1, class2, class3, class4, class5,
               K_mode_out, out_count, out_valid
    );

    modport slave (
        input  start, K_mode, in_valid, in_dist, in_label, in_last, out_ready,
        output in_ready, class1, class2, class3, class4, class5,
               K_mode_out, out_count, out_valid
    );
endinterface

// File: rtl/knn_topk_select.sv
// Streaming top-5 nearest-neighbour selector: keeps a stably sorted five-entry list
// of (distance, label) and presents the labels once the last sample of a query arrives.
module knn_topk_select #(
    parameter int DIST_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    knn_topk_select_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [4:0]        occ_r;
    logic [DIST_W-1:0] dist_r  [5];
    logic [1:0]        label_r [5];
    logic [2:0]        count_r;
    logic              kmode_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              start_s;
    logic              accept_s;
    logic [4:0]        gt_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode plus query-start and sample-accept strobes.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    start_s    = 1'b1;
                    state_nx_s = COLLECT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            COLLECT: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s   = 1'b1;
                    state_nx_s = bus.in_last ? DONE : COLLECT;
                end else begin
                    state_nx_s = COLLECT;
                end
            end
            DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Per-slot "new sample belongs at or before here"; equal distances do not qualify,
    // which keeps ties stable. The vector is monotone because the list stays sorted.
    always_comb begin
        gt_s = 5'b0_0000;
        for (int i = 0; i < 5; i++) begin
            gt_s[i] = !occ_r[i] || (dist_r[i] > bus.in_dist);
        end
    end

    // Sorted slot list: cleared on start, one-cycle insert with shift-down on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r <= 5'b0_0000;
            for (int i = 0; i < 5; i++) begin
                dist_r[i]  <= {DIST_W{1'b0}};
                label_r[i] <= 2'd0;
            end
        end else if (start_s) begin
            occ_r <= 5'b0_0000;
            for (int i = 0; i < 5; i++) begin
                dist_r[i]  <= {DIST_W{1'b0}};
                label_r[i] <= 2'd0;
            end
        end else if (accept_s) begin
            if (gt_s[0]) begin
                occ_r[0]   <= 1'b1;
                dist_r[0]  <= bus.in_dist;
                label_r[0] <= bus.in_label;
            end
            for (int i = 1; i < 5; i++) begin
                if (gt_s[i] && !gt_s[i-1]) begin
                    occ_r[i]   <= 1'b1;
                    dist_r[i]  <= bus.in_dist;
                    label_r[i] <= bus.in_label;
                end else if (gt_s[i]) begin
                    occ_r[i]   <= occ_r[i-1];
                    dist_r[i]  <= dist_r[i-1];
                    label_r[i] <= label_r[i-1];
                end
            end
        end
    end

    // Result bookkeeping and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= 3'd0;
            kmode_r     <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (start_s) begin
                count_r <= 3'd0;
                kmode_r <= bus.K_mode;
            end else if (accept_s && (count_r != 3'd5)) begin
                count_r <= count_r + 3'd1;
            end
            in_ready_r  <= (state_nx_s == COLLECT);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Unoccupied slots always carry label 0, so labels drive the class outputs directly.
    assign bus.class1     = label_r[0];
    assign bus.class2     = label_r[1];
    assign bus.class3     = label_r[2];
    assign bus.class4     = label_r[3];
    assign bus.class5     = label_r[4];
    assign bus.out_count  = count_r;
    assign bus.K_mode_out = kmode_r;
    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;

endmodule
